// File: rtl/leb128_decoder.sv
// leb128_decoder
//   Decodes one WebAssembly LEB128 immediate (ULEB/SLEB, 32- or 64-bit
//   target) from a byte stream and returns it zero- or sign-extended
//   to 64 bits, together with its byte length.
//
// Ports
//   clk, reset     clock; asynchronous active-low reset
//   start, mode    begin a decode; mode[0] = signed, mode[1] = 64-bit target
//   in_data/in_valid/in_ready     byte stream handshake
//   out_value/out_len/out_valid/out_ready   result handshake
//   busy           FSM is not idle
//   error          malformed/overflowing immediate (sticky until next start)
//
// Configuration macro: LEB128_OVERFLOW_CHECK_EN
//   defined   : continuation on the last legal byte, or out-of-range bits
//               in it, send the FSM to ERR.
//   undefined : the last legal byte is always final, excess bits are
//               truncated, error is tied low.
module leb128_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_value,
  output logic [3:0]  out_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERR} state_t;

  state_t      state, state_d;
  logic [1:0]  mode_q;
  logic [63:0] acc;
  logic [3:0]  count;

  logic        accept, load, last_slot, fin, ovf;
  logic [6:0]  sh;
  logic [7:0]  fill_sh;
  logic [63:0] acc_new, fill_mask, ext;

  assign accept    = (state == ACCUM) && in_valid;
  assign last_slot = (count == (mode_q[1] ? 4'd9 : 4'd4));

  // A new decode may begin from IDLE, from ERR, or from DONE on the same
  // cycle the result is taken (back-to-back).
  assign load = start && ((state == IDLE) || (state == ERR) ||
                          ((state == DONE) && out_ready));

  assign sh      = {3'b000, count} * 7'd7;
  assign fill_sh = {4'b0000, count} * 8'd7 + 8'd7;
  assign acc_new = acc | ({57'd0, in_data[6:0]} << sh);

  // Ones above the last payload bit for a negative SLEB; nothing to fill
  // once the payload already reaches bit 63.
  assign fill_mask = (fill_sh >= 8'd64) ? 64'd0 : ({64{1'b1}} << fill_sh);

  always_comb begin
    ext = acc_new;
    if (mode_q[0] && in_data[6]) ext = ext | fill_mask;
    if (!mode_q[1]) ext[63:32] = mode_q[0] ? {32{ext[31]}} : 32'd0;
  end

`ifdef LEB128_OVERFLOW_CHECK_EN
  logic range_ok;
  always_comb begin
    case (mode_q)
      2'b00:   range_ok = (in_data[6:4] == 3'd0);
      2'b01:   range_ok = (in_data[6:3] == 4'h0) || (in_data[6:3] == 4'hF);
      2'b10:   range_ok = (in_data[6:1] == 6'd0);
      default: range_ok = (in_data[6:0] == 7'h00) || (in_data[6:0] == 7'h7F);
    endcase
  end
  assign ovf   = accept && last_slot && (in_data[7] || !range_ok);
  assign fin   = accept && !in_data[7] && !ovf;
  assign error = (state == ERR);
`else
  assign ovf   = 1'b0;
  assign fin   = accept && (!in_data[7] || last_slot);
  assign error = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM: begin
        if (ovf)      state_d = ERR;
        else if (fin) state_d = DONE;
      end
      DONE:    if (out_ready) state_d = start ? ACCUM : IDLE;
      ERR:     if (start) state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= 2'b00;
      acc       <= 64'd0;
      count     <= 4'd0;
      out_value <= 64'd0;
      out_len   <= 4'd0;
    end else begin
      if (load) begin
        mode_q <= mode;
        acc    <= 64'd0;
        count  <= 4'd0;
      end else if (accept) begin
        acc   <= acc_new;
        count <= count + 4'd1;
      end
      if (fin) begin
        out_value <= ext;
        out_len   <= count + 4'd1;
      end
    end
  end

  // Outputs depend on registered state only.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
